// File: rtl/iq_demux_two_outputs.sv
// Splits interleaved little-endian 16-bit I/Q bytes into two quantized 32-bit
// streams, pushing I and Q together once a full 4-byte group has been popped.
module iq_quant #(
    parameter int DATA_WIDTH = 32,
    parameter int QUANT_BITS = 10
) (
    input  logic [15:0]           raw,
    output logic [DATA_WIDTH-1:0] quant
);
    logic [DATA_WIDTH-1:0] ext;

    assign ext   = {{(DATA_WIDTH-16){raw[15]}}, raw};
    assign quant = ext << QUANT_BITS;
endmodule

module iq_demux_two_outputs #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int QUANT_BITS = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  in_rd_en,
    input  logic                  in_empty,
    input  logic [BYTE_WIDTH-1:0] in_dout,
    output logic                  i_out_wr_en,
    input  logic                  i_out_full,
    output logic [DATA_WIDTH-1:0] i_out_din,
    output logic                  q_out_wr_en,
    input  logic                  q_out_full,
    output logic [DATA_WIDTH-1:0] q_out_din
);
    typedef enum logic {S_READ, S_WRITE} state_t;

    state_t                      state, state_next;
    logic [1:0]                  byte_cnt;
    // sample[0] is I, sample[1] is Q; byte_cnt[1] picks the component
    logic [1:0][15:0]            sample;
    logic [1:0][DATA_WIDTH-1:0]  quant;

    always_comb begin
        state_next  = state;
        in_rd_en    = 1'b0;
        i_out_wr_en = 1'b0;
        q_out_wr_en = 1'b0;
        case (state)
            S_READ: begin
                in_rd_en = reset && !in_empty;
                if (in_rd_en && byte_cnt == 2'd3)
                    state_next = S_WRITE;
            end
            S_WRITE: begin
                // I and Q are only ever pushed as a pair
                if (reset && !i_out_full && !q_out_full) begin
                    i_out_wr_en = 1'b1;
                    q_out_wr_en = 1'b1;
                    state_next  = S_READ;
                end
            end
            default: state_next = S_READ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_READ;
            byte_cnt <= 2'd0;
            sample   <= '0;
        end else begin
            state <= state_next;
            if (in_rd_en) begin
                byte_cnt <= byte_cnt + 2'd1;
                sample[byte_cnt[1]][{byte_cnt[0], 3'b000} +: 8] <= in_dout[7:0];
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_quant
        iq_quant #(
            .DATA_WIDTH(DATA_WIDTH),
            .QUANT_BITS(QUANT_BITS)
        ) u_quant (
            .raw  (sample[g]),
            .quant(quant[g])
        );
    end

    assign i_out_din = quant[0];
    assign q_out_din = quant[1];
endmodule
